decoder_n_to_2n_seq: RTL and testbench

//  Parametrised, registered N-to-2^N one-hot decoder with enable; successor to the 3-to-8 decoder.
//  Two modes:
//  - DIRECT: latches an address and drives the matching output line.
//  - SWEEP: walks every output line in turn, for lamp/strobe tests of downstream select lines.

---
 rtl/decoder_n_to_2n_seq.sv | 139 +++++++++++++
 tb/tb_decoder_n_to_2n_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_n_to_2n_seq.sv
// Registered N-to-2^N one-hot (or one-cold) decoder with a DIRECT latched-address
// mode and a SWEEP mode that walks every output line for strobe/lamp tests.
module decoder_n_to_2n_seq #(
  parameter int unsigned N           = 3,
  parameter int unsigned STEP_CYCLES = 1,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load_i,
  input  logic [N-1:0]        addr_i,
  input  logic                start_i,
  output logic [(2**N)-1:0]   y_o,
  output logic                valid_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned LINES = 2 ** N;
  localparam int unsigned HW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [N-1:0]     LAST_STEP = N'(LINES - 1);
  localparam logic [HW-1:0]    LAST_HOLD = HW'(STEP_CYCLES - 1);
  localparam logic [LINES-1:0] INACT     = {LINES{ACTIVE_LOW}};

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [N-1:0]      step, step_nxt;
  logic [HW-1:0]     hold, hold_nxt;
  logic [N-1:0]      addr_q, addr_nxt;
  logic              addr_ok, addr_ok_nxt;
  logic [LINES-1:0]  y_nxt;
  logic              valid_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  function automatic logic [LINES-1:0] onehot(input logic [N-1:0] a);
    return LINES'(1) << a;
  endfunction

  // Applies output polarity to an active-high one-hot pattern.
  function automatic logic [LINES-1:0] drive(input logic [LINES-1:0] hot);
    return ACTIVE_LOW ? ~hot : hot;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    step_nxt    = step;
    hold_nxt    = hold;
    addr_nxt    = addr_q;
    addr_ok_nxt = addr_ok;
    y_nxt       = INACT;
    valid_nxt   = 1'b0;
    busy_nxt    = busy_o;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = SWEEP;
          step_nxt  = '0;
          hold_nxt  = '0;
          busy_nxt  = 1'b1;
          if (en) begin
            y_nxt     = drive(onehot('0));
            valid_nxt = 1'b1;
          end
        end else if (load_i) begin
          addr_nxt    = addr_i;
          addr_ok_nxt = 1'b1;
          if (en) begin
            y_nxt     = drive(onehot(addr_i));
            valid_nxt = 1'b1;
          end
        end else if (en && addr_ok) begin
          y_nxt     = drive(onehot(addr_q));
          valid_nxt = 1'b1;
        end
      end

      SWEEP: begin
        // en=0 pauses the walk with step and hold frozen.
        if (en) begin
          if ((step == LAST_STEP) && (hold == LAST_HOLD)) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            if (hold == LAST_HOLD) begin
              hold_nxt = '0;
              step_nxt = step + N'(1);
            end else begin
              hold_nxt = hold + HW'(1);
            end
            y_nxt     = drive(onehot(step_nxt));
            valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      step    <= '0;
      hold    <= '0;
      addr_q  <= '0;
      addr_ok <= 1'b0;
      y_o     <= INACT;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      step    <= step_nxt;
      hold    <= hold_nxt;
      addr_q  <= addr_nxt;
      addr_ok <= addr_ok_nxt;
      y_o     <= y_nxt;
      valid_o <= valid_nxt;
      busy_o  <= busy_nxt;
      done_o  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_n_to_2n_seq.sv
// Bench for decoder_n_to_2n_seq: three instances (default, STEP_CYCLES=3, ACTIVE_LOW=1)
// share stimulus and are checked each cycle against a progress-count model.
module tb_decoder_n_to_2n_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load_i = 1'b0;
  logic       start_i = 1'b0;
  logic [2:0] addr_i = 3'd0;

  logic [7:0] y_a [3];
  logic       v_a [3];
  logic       b_a [3];
  logic       d_a [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  decoder_n_to_2n_seq #(.N(3), .STEP_CYCLES(1), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .load_i(load_i), .addr_i(addr_i), .start_i(start_i),
    .y_o(y_a[0]), .valid_o(v_a[0]), .busy_o(b_a[0]), .done_o(d_a[0]));
  decoder_n_to_2n_seq #(.N(3), .STEP_CYCLES(3), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .load_i(load_i), .addr_i(addr_i), .start_i(start_i),
    .y_o(y_a[1]), .valid_o(v_a[1]), .busy_o(b_a[1]), .done_o(d_a[1]));
  decoder_n_to_2n_seq #(.N(3), .STEP_CYCLES(1), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .load_i(load_i), .addr_i(addr_i), .start_i(start_i),
    .y_o(y_a[2]), .valid_o(v_a[2]), .busy_o(b_a[2]), .done_o(d_a[2]));

  function automatic int sc_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic bit al_of(input int i);
    return (i == 2);
  endfunction

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d at %0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  // Model: a sweep is a count p of enabled edges since start; line = p / STEP_CYCLES.
  logic       m_busy [3];
  int         m_p    [3];
  logic [2:0] m_addr [3];
  logic       m_ok   [3];
  logic [7:0] m_y    [3];
  logic       m_v    [3];
  logic       m_d    [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0; m_p[i] <= 0; m_addr[i] <= 3'd0; m_ok[i] <= 1'b0;
        m_y[i] <= 8'h00; m_v[i] <= 1'b0; m_d[i] <= 1'b0;
      end else if (m_busy[i]) begin
        if (!en) begin
          m_y[i] <= 8'h00; m_v[i] <= 1'b0; m_d[i] <= 1'b0;
        end else if (m_p[i] + 1 == 8 * sc_of(i)) begin
          m_busy[i] <= 1'b0; m_d[i] <= 1'b1; m_y[i] <= 8'h00; m_v[i] <= 1'b0; m_p[i] <= 0;
        end else begin
          m_p[i] <= m_p[i] + 1;
          m_y[i] <= 8'(1) << ((m_p[i] + 1) / sc_of(i));
          m_v[i] <= 1'b1; m_d[i] <= 1'b0;
        end
      end else begin
        m_d[i] <= 1'b0;
        if (start_i) begin
          m_busy[i] <= 1'b1; m_p[i] <= 0;
          m_y[i] <= en ? 8'h01 : 8'h00; m_v[i] <= en;
        end else if (load_i) begin
          m_addr[i] <= addr_i; m_ok[i] <= 1'b1;
          m_y[i] <= en ? (8'(1) << addr_i) : 8'h00; m_v[i] <= en;
        end else begin
          m_y[i] <= (en && m_ok[i]) ? (8'(1) << m_addr[i]) : 8'h00;
          m_v[i] <= en && m_ok[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk("model_y", i, y_a[i], al_of(i) ? ~m_y[i] : m_y[i]);
        chk("model_valid", i, 8'(v_a[i]), 8'(m_v[i]));
        chk("model_busy", i, 8'(b_a[i]), 8'(m_busy[i]));
        chk("model_done", i, 8'(d_a[i]), 8'(m_d[i]));
      end
    end
  end

  task automatic wait_idle(input int i);
    int n = 0;
    while (b_a[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", i, 8'(b_a[i]), 8'h00);
  endtask

  int  edges;
  int  cnt2;
  bit  saw_done;

  task automatic step_count();
    @(negedge clk);
    edges++;
    if (y_a[1] == 8'h04) cnt2++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_y", 0, y_a[0], 8'h00);
    chk("rst_y", 2, y_a[2], 8'hFF);
    chk("rst_busy", 1, 8'(b_a[1]), 8'h00);
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);

    // Direct load of address 6
    load_i = 1'b1; addr_i = 3'b110;
    @(negedge clk);
    load_i = 1'b0; addr_i = 3'd0;
    chk("t1_y", 0, y_a[0], 8'h40);
    chk("t1_valid", 0, 8'(v_a[0]), 8'h01);
    chk("t1_y_al", 2, y_a[2], 8'hBF);
    @(negedge clk);
    chk("t1_hold", 0, y_a[0], 8'h40);

    // Enable gap
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t2_gap_y", 0, y_a[0], 8'h00);
      chk("t2_gap_valid", 0, 8'(v_a[0]), 8'h00);
    end
    en = 1'b1;
    @(negedge clk);
    chk("t2_back", 0, y_a[0], 8'h40);

    // Full sweep, STEP_CYCLES=1
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("t3_line0", 0, y_a[0], 8'h01);
    chk("t3_line0_al", 2, y_a[2], 8'hFE);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("t3_line", 0, y_a[0], 8'(1) << k);
    end
    @(negedge clk);
    chk("t3_done", 0, 8'(d_a[0]), 8'h01);
    chk("t3_done_y", 0, y_a[0], 8'h00);
    chk("t3_done_busy", 0, 8'(b_a[0]), 8'h00);
    @(negedge clk);
    chk("t3_resume_y", 0, y_a[0], 8'h40);
    chk("t3_resume_valid", 0, 8'(v_a[0]), 8'h01);
    wait_idle(1);
    @(negedge clk);

    // STEP_CYCLES=3 sweep paused for 4 edges while on line 2
    edges = 0; cnt2 = 0;
    start_i = 1'b1;
    step_count();
    start_i = 1'b0;
    repeat (6) step_count();
    chk("t4_at_line2", 1, y_a[1], 8'h04);
    en = 1'b0;
    repeat (4) step_count();
    en = 1'b1;
    while (!d_a[1] && edges < 60) step_count();
    chk("t4_done_edge", 1, 8'(edges), 8'd29);
    chk("t4_line2_cycles", 1, 8'(cnt2), 8'd3);
    wait_idle(0);
    @(negedge clk);

    // Start and load together, then a load mid-sweep: both loads ignored
    start_i = 1'b1; load_i = 1'b1; addr_i = 3'd5;
    @(negedge clk);
    start_i = 1'b0; load_i = 1'b0;
    chk("t5_sweep_y", 0, y_a[0], 8'h01);
    chk("t5_busy", 0, 8'(b_a[0]), 8'h01);
    repeat (3) @(negedge clk);
    load_i = 1'b1; addr_i = 3'd2;
    @(negedge clk);
    load_i = 1'b0;
    wait_idle(0);
    wait_idle(1);
    @(negedge clk);
    chk("t5_keep", 0, y_a[0], 8'h40);
    chk("t5_keep", 1, y_a[1], 8'h40);

    // Reset mid-sweep
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_line4", 0, y_a[0], 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_y", 0, y_a[0], 8'h00);
    chk("t6_rst_busy", 0, 8'(b_a[0]), 8'h00);
    chk("t6_rst_y_al", 2, y_a[2], 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (d_a[0] || d_a[1] || d_a[2]) saw_done = 1'b1;
    end
    chk("t6_no_done", 0, 8'(saw_done), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
